ascon_tv_player: RTL and testbench

- Synthesizable, parametrised successor to the file-driven Ascon bench stimulus.
- Consumes a 32-bit INS/DAT word stream, packs it into CCW/CCSW-wide beats and drives the ascon_core key/bdi/mode interface with full backpressure.
- Captures bdo and auth results into a result FIFO.
- Sits between an on-chip vector source (BRAM, UART, host bus) and ascon_core, for FPGA self-test and hardware-in-loop runs.

---
 rtl/ascon_tv_player_pkg.sv | 46 ++++
 rtl/ascon_res_fifo.sv | 52 +++++
 rtl/ascon_tv_player.sv | 213 +++++++++++++++++++++
 tb/tb_ascon_tv_player.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_tv_player_pkg.sv
// Shared definitions for the Ascon test-vector player: instruction opcodes,
// bdi segment type codes, default widths and the player FSM state type.
package ascon_tv_player_pkg;

  localparam int CCW_DEF       = 32;
  localparam int CCSW_DEF      = 32;
  localparam int RES_DEPTH_DEF = 4;

  // Instruction opcodes carried in INS word bits [31:28]
  localparam logic [3:0] OP_LD_KEY   = 4'h1;
  localparam logic [3:0] OP_LD_NONCE = 4'h2;
  localparam logic [3:0] OP_LD_AD    = 4'h3;
  localparam logic [3:0] OP_LD_PT    = 4'h4;
  localparam logic [3:0] OP_LD_CT    = 4'h5;
  localparam logic [3:0] OP_LD_TAG   = 4'h6;
  localparam logic [3:0] OP_DO_ENC   = 4'h8;
  localparam logic [3:0] OP_DO_DEC   = 4'h9;
  localparam logic [3:0] OP_DO_HASH  = 4'hA;

  // bdi / bdo segment types
  localparam logic [3:0] D_NULL  = 4'h0;
  localparam logic [3:0] D_AD    = 4'h1;
  localparam logic [3:0] D_PTCT  = 4'h4;
  localparam logic [3:0] D_TAG   = 4'h8;
  localparam logic [3:0] D_NONCE = 4'hC;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} tv_state_t;

  // True for any opcode that opens a data/key segment
  function automatic logic is_ld_op(input logic [3:0] op);
    return (op == OP_LD_KEY) || (op == OP_LD_NONCE) || (op == OP_LD_AD) ||
           (op == OP_LD_PT)  || (op == OP_LD_CT)    || (op == OP_LD_TAG);
  endfunction

  // Segment type presented on bdi_type for a load opcode
  function automatic logic [3:0] op_to_type(input logic [3:0] op);
    case (op)
      OP_LD_NONCE:         return D_NONCE;
      OP_LD_AD:            return D_AD;
      OP_LD_PT, OP_LD_CT:  return D_PTCT;
      OP_LD_TAG:           return D_TAG;
      default:             return D_NULL;
    endcase
  endfunction

endpackage

// File: rtl/ascon_res_fifo.sv
// Synchronous result FIFO. A write into a full FIFO is accepted only when a
// pop happens in the same cycle; there is no empty bypass. The head output
// reads 0 while empty so stale entries never leak out after a reset.
module ascon_res_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_wr, do_rd;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rp];

  // Storage array, written at the write pointer
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ascon_tv_player.sv
// Ascon test-vector player: turns a 32-bit INS/DAT word stream into key/bdi
// beats for ascon_core and collects bdo/auth results.
// Optional beat counters are built when ASCON_TV_STATS_EN is defined.
module ascon_tv_player
  import ascon_tv_player_pkg::*;
#(
  parameter int CCW       = CCW_DEF,
  parameter int CCSW      = CCW,
  parameter int RES_DEPTH = RES_DEPTH_DEF
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     tv_data,
  input  logic            tv_is_ins,
  input  logic            tv_valid,
  output logic            tv_ready,
  output logic [CCSW-1:0] key,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [CCW-1:0]  bdi,
  output logic            bdi_valid,
  input  logic            bdi_ready,
  output logic [3:0]      bdi_type,
  output logic            bdi_eot,
  output logic            bdi_eoi,
  output logic            decrypt,
  output logic            hash,
  input  logic [CCW-1:0]  bdo,
  input  logic            bdo_valid,
  output logic            bdo_ready,
  input  logic [3:0]      bdo_type,
  input  logic            bdo_eot,
  input  logic            auth,
  input  logic            auth_valid,
  output logic            auth_ready,
  output logic [CCW-1:0]  res_data,
  output logic [3:0]      res_type,
  output logic            res_eot,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            auth_out,
  output logic            auth_out_valid,
  output logic            err,
  output logic [31:0]     stat_bdi_beats,
  output logic [31:0]     stat_bdo_beats
);
  localparam int MAXW    = (CCW > CCSW) ? CCW : CCSW;
  localparam int MAXWPB  = MAXW / 32;
  localparam int WPB_KEY = CCSW / 32;
  localparam int WPB_DAT = CCW / 32;
  localparam int RW      = CCW + 5;

  tv_state_t        state, state_nxt;
  logic [3:0]       op_r, type_r;
  logic             eoi_flag_r;
  logic [22:0]      words_left;   // DAT words still to be accepted in segment
  logic [1:0]       widx;         // word slot within current beat
  logic [MAXW-1:0]  beat;

  logic        tv_hs, is_key, last_word, last_beat, out_hs;
  logic [3:0]  ins_op;
  logic [23:0] ins_len;
  logic [24:0] len_p3;
  logic [22:0] ins_nwords;
  logic [1:0]  wpb_cur, pos;
  logic        fifo_full, fifo_empty;
  logic [RW-1:0] fifo_rd;

  assign tv_hs      = tv_valid & tv_ready;
  assign ins_op     = tv_data[31:28];
  assign ins_len    = tv_data[23:0];
  assign len_p3     = {1'b0, ins_len} + 25'd3;
  assign ins_nwords = len_p3[24:2];
  assign is_key     = (op_r == OP_LD_KEY);
  assign wpb_cur    = is_key ? 2'(WPB_KEY) : 2'(WPB_DAT);
  // Beats are filled MSB-first, so slot 0 lands in the highest word
  assign pos        = wpb_cur - 2'd1 - widx;
  assign last_word  = (widx == wpb_cur - 2'd1) | (words_left == 23'd1);
  assign last_beat  = (words_left == '0);
  assign out_hs     = is_key ? (key_valid & key_ready) : (bdi_valid & bdi_ready);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (tv_hs && tv_is_ins && is_ld_op(ins_op) && ins_len != '0)
              state_nxt = LOAD;
      LOAD: if (tv_hs && !tv_is_ins && last_word)
              state_nxt = SEND;
      SEND: if (out_hs)
              state_nxt = last_beat ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; the word stream is held off while a beat is outstanding
  always_comb begin
    tv_ready   = ~rst & (state != SEND);
    key_valid  = (state == SEND) & is_key;
    bdi_valid  = (state == SEND) & ~is_key;
    key        = key_valid ? beat[CCSW-1:0] : '0;
    bdi        = bdi_valid ? beat[CCW-1:0]  : '0;
    bdi_type   = bdi_valid ? type_r : D_NULL;
    bdi_eot    = bdi_valid & last_beat;
    bdi_eoi    = bdi_valid & last_beat & eoi_flag_r;
    auth_ready = ~rst;
    bdo_ready  = ~rst & ~fifo_full;
  end

  // Segment bookkeeping, beat assembly, mode bits and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= '0;
      type_r     <= D_NULL;
      eoi_flag_r <= 1'b0;
      words_left <= '0;
      widx       <= '0;
      beat       <= '0;
      decrypt    <= 1'b0;
      hash       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tv_hs) begin
          if (!tv_is_ins) begin
            err <= 1'b1;
          end else if (is_ld_op(ins_op)) begin
            op_r       <= ins_op;
            type_r     <= op_to_type(ins_op);
            eoi_flag_r <= tv_data[24];
            words_left <= ins_nwords;
            widx       <= '0;
            beat       <= '0;
          end else begin
            case (ins_op)
              OP_DO_ENC:  {decrypt, hash} <= 2'b00;
              OP_DO_DEC:  {decrypt, hash} <= 2'b10;
              OP_DO_HASH: {decrypt, hash} <= 2'b01;
              default:    err <= 1'b1;
            endcase
          end
        end
        LOAD: if (tv_hs) begin
          if (tv_is_ins) begin
            err <= 1'b1;
          end else begin
            for (int i = 0; i < MAXWPB; i++)
              if (pos == 2'(i)) beat[i*32 +: 32] <= tv_data;
            words_left <= words_left - 23'd1;
            widx       <= last_word ? 2'd0 : widx + 2'd1;
          end
        end
        SEND: if (out_hs) beat <= '0;
        default: ;
      endcase
    end
  end

  // Tag verification result, latched with a one-cycle valid pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auth_out       <= 1'b0;
      auth_out_valid <= 1'b0;
    end else begin
      auth_out_valid <= auth_valid;
      if (auth_valid) auth_out <= auth;
    end
  end

  ascon_res_fifo #(.W(RW), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bdo_valid & bdo_ready),
    .wr_data ({bdo, bdo_type, bdo_eot}),
    .full    (fifo_full),
    .rd_en   (res_ready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty)
  );

  assign res_valid = ~fifo_empty;
  assign res_data  = fifo_rd[RW-1:5];
  assign res_type  = fifo_rd[4:1];
  assign res_eot   = fifo_rd[0];

`ifdef ASCON_TV_STATS_EN
  logic [31:0] bdi_cnt, bdo_cnt;

  // Handshake counters, free-running and wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bdi_cnt <= '0;
      bdo_cnt <= '0;
    end else begin
      if ((key_valid & key_ready) | (bdi_valid & bdi_ready)) bdi_cnt <= bdi_cnt + 32'd1;
      if (bdo_valid & bdo_ready) bdo_cnt <= bdo_cnt + 32'd1;
    end
  end

  assign stat_bdi_beats = bdi_cnt;
  assign stat_bdo_beats = bdo_cnt;
`else
  assign stat_bdi_beats = '0;
  assign stat_bdo_beats = '0;
`endif

endmodule

// File: tb/tb_ascon_tv_player.sv
// Scoreboard bench for ascon_tv_player (CCW=64, CCSW=32, RES_DEPTH=4).
module tb_ascon_tv_player;
  import ascon_tv_player_pkg::*;

  localparam int CCW = 64, CCSW = 32, RD = 4;

  logic clk = 0, rst = 1;
  logic [31:0] tv_data = '0;
  logic tv_is_ins = 0, tv_valid = 0, tv_ready;
  logic [CCSW-1:0] key;
  logic key_valid, key_ready = 0;
  logic [CCW-1:0] bdi;
  logic bdi_valid, bdi_ready = 0;
  logic [3:0] bdi_type;
  logic bdi_eot, bdi_eoi, decrypt, hash;
  logic [CCW-1:0] bdo = '0;
  logic bdo_valid = 0, bdo_ready;
  logic [3:0] bdo_type = '0;
  logic bdo_eot = 0, auth = 0, auth_valid = 0, auth_ready;
  logic [CCW-1:0] res_data;
  logic [3:0] res_type;
  logic res_eot, res_valid, res_ready = 0;
  logic auth_out, auth_out_valid, err;
  logic [31:0] stat_bdi_beats, stat_bdo_beats;

  ascon_tv_player #(.CCW(CCW), .CCSW(CCSW), .RES_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .tv_data(tv_data), .tv_is_ins(tv_is_ins),
    .tv_valid(tv_valid), .tv_ready(tv_ready), .key(key), .key_valid(key_valid),
    .key_ready(key_ready), .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
    .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi), .decrypt(decrypt),
    .hash(hash), .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
    .bdo_type(bdo_type), .bdo_eot(bdo_eot), .auth(auth), .auth_valid(auth_valid),
    .auth_ready(auth_ready), .res_data(res_data), .res_type(res_type),
    .res_eot(res_eot), .res_valid(res_valid), .res_ready(res_ready),
    .auth_out(auth_out), .auth_out_valid(auth_out_valid), .err(err),
    .stat_bdi_beats(stat_bdi_beats), .stat_bdo_beats(stat_bdo_beats)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_key; logic [63:0] data; logic [3:0] typ; logic eot, eoi; } beat_t;
  typedef struct { logic [CCW-1:0] d; logic [3:0] t; logic e; } res_t;

  beat_t exp_q[$];
  res_t  res_q[$];
  logic [31:0] wq[$];
  int checks = 0, errors = 0;
  int rmode = 0, res_mode = 0, n_in = 0, n_out = 0, bdo_done = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [3:0] type_of(input logic [3:0] op);
    if (op == OP_LD_NONCE) return D_NONCE;
    if (op == OP_LD_AD) return D_AD;
    if (op == OP_LD_PT || op == OP_LD_CT) return D_PTCT;
    if (op == OP_LD_TAG) return D_TAG;
    return D_NULL;
  endfunction

  // Reference: slice the word list into beats of BW bits, MSB word first, zero padded
  function automatic void model_seg(input logic [3:0] op, input logic [3:0] fl, input int len);
    int bw, wpb, nw, nb;
    bw = (op == OP_LD_KEY) ? CCSW : CCW;
    wpb = bw / 32; nw = (len + 3) / 4; nb = (nw + wpb - 1) / wpb;
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      logic [63:0] v;
      v = '0;
      for (int j = 0; j < wpb; j++)
        if (b*wpb + j < nw) v[bw-1-32*j -: 32] = wq[b*wpb + j];
      e.is_key = (op == OP_LD_KEY);
      e.data = v;
      e.typ = type_of(op);
      e.eot = (b == nb - 1) && !e.is_key;
      e.eoi = e.eot & fl[0];
      exp_q.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [31:0] d, input logic ins);
    int n = 0;
    tv_data = d; tv_is_ins = ins; tv_valid = 1;
    while (!tv_ready && n < 500) begin tick(); n++; end
    if (n >= 500) chk("tv_ready_timeout", 0, 1);
    tick();
    tv_valid = 0;
  endtask

  task automatic seg(input logic [3:0] op, input logic [3:0] fl, input int len);
    model_seg(op, fl, len);
    put({op, fl, 24'(len)}, 1);
    for (int i = 0; i < (len + 3) / 4; i++) put(wq[i], 0);
  endtask

  task automatic rnd_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !tv_ready) && n < 2000) begin tick(); n++; end
    chk("beats_drained", exp_q.size(), 0);
  endtask

  task automatic send_bdo(input logic [CCW-1:0] d, input logic [3:0] t, input logic e);
    int n = 0;
    res_t r;
    r.d = d; r.t = t; r.e = e;
    res_q.push_back(r);
    bdo = d; bdo_type = t; bdo_eot = e; bdo_valid = 1;
    while (!bdo_ready && n < 500) begin tick(); n++; end
    if (n >= 500) chk("bdo_ready_timeout", 0, 1);
    tick();
    bdo_valid = 0;
    bdo_done++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tv_ready"}, tv_ready, 0);
    chk({tag, "_key_valid"}, key_valid, 0);
    chk({tag, "_key"}, key, 0);
    chk({tag, "_bdi_valid"}, bdi_valid, 0);
    chk({tag, "_bdi"}, bdi, 0);
    chk({tag, "_bdi_flags"}, {bdi_type, bdi_eot, bdi_eoi}, 0);
    chk({tag, "_mode"}, {decrypt, hash}, 0);
    chk({tag, "_bdo_ready"}, bdo_ready, 0);
    chk({tag, "_auth_ready"}, auth_ready, 0);
    chk({tag, "_res"}, {res_valid, res_data, res_type, res_eot}, 0);
    chk({tag, "_auth_out"}, {auth_out, auth_out_valid}, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_stats"}, {stat_bdi_beats, stat_bdo_beats}, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; all outputs must drop at once
  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    rst = 1; #1;
    chk_zero(tag);
    exp_q.delete(); res_q.delete();
    n_in = 0; n_out = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk({tag, "_auth_ready_after"}, auth_ready, 1);
  endtask

  // Core-side ready drivers
  initial forever begin
    tick();
    case (rmode)
      0: begin key_ready = 1; bdi_ready = 1; end
      1: begin key_ready = 1'($urandom_range(0, 1)); bdi_ready = 1'($urandom_range(0, 1)); end
      default: begin key_ready = 0; bdi_ready = 0; end
    endcase
    case (res_mode)
      0: res_ready = 0;
      1: res_ready = 1'($urandom_range(0, 1));
      default: res_ready = ~res_ready;
    endcase
  end

  // Monitor: pops expected beats/results when the DUT hands them over
  logic pend = 0;
  logic [CCW-1:0] p_bdi;
  logic [CCSW-1:0] p_key;
  logic [5:0] p_ctl;
  always @(negedge clk) begin
    if (rst) begin
      pend <= 0;
    end else begin
      beat_t e;
      res_t r;
      if (key_valid || bdi_valid) chk("tv_ready_in_send", tv_ready, 0);
      if (pend) begin
        chk("valid_held", key_valid | bdi_valid, 1);
        chk("key_stable", key, p_key);
        chk("bdi_stable", bdi, p_bdi);
        chk("ctl_stable", {bdi_type, bdi_eot, bdi_eoi}, p_ctl);
      end
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) chk("unexpected_key_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_is_key", 1, 64'(e.is_key));
          chk("key_data", key, e.data[CCSW-1:0]);
          chk("key_eot", bdi_eot, 0);
        end
        n_in++;
      end
      if (bdi_valid && bdi_ready) begin
        if (exp_q.size() == 0) chk("unexpected_bdi_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_is_bdi", 0, 64'(e.is_key));
          chk("bdi_data", bdi, e.data);
          chk("bdi_type", bdi_type, e.typ);
          chk("bdi_eot_eoi", {bdi_eot, bdi_eoi}, {e.eot, e.eoi});
        end
        n_in++;
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          r = res_q.pop_front();
          chk("res_data", res_data, r.d);
          chk("res_type_eot", {res_type, res_eot}, {r.t, r.e});
        end
      end
      if (bdo_valid && bdo_ready) n_out++;
      pend  <= (key_valid & ~key_ready) | (bdi_valid & ~bdi_ready);
      p_key <= key; p_bdi <= bdi; p_ctl <= {bdi_type, bdi_eot, bdi_eoi};
    end
  end

  initial begin
    logic [3:0] ops [6] = '{OP_LD_KEY, OP_LD_NONCE, OP_LD_AD, OP_LD_PT, OP_LD_CT, OP_LD_TAG};
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_zero("rst");
    #1 rst = 0;
    #1;
    chk("auth_ready_out_of_rst", auth_ready, 1);
    chk("tv_ready_idle", tv_ready, 1);
    chk("bdo_ready_empty", bdo_ready, 1);

    // Key load: 4 beats of 32 bits
    rmode = 0;
    wq = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    seg(OP_LD_KEY, 4'h0, 16);
    drain();

    // AD, short final beat zero padded, eoi flag set
    wq = '{32'h11111111, 32'h22222222, 32'h33333333};
    seg(OP_LD_AD, 4'h1, 12);
    drain();

    // Backpressure: core stalls a nonce beat for 5 cycles
    rmode = 2;
    wq = '{32'hdeadbeef, 32'hcafef00d};
    seg(OP_LD_NONCE, 4'h0, 8);
    for (int i = 0; i < 5; i++) begin
      chk("stall_bdi_valid", bdi_valid, 1);
      chk("stall_tv_ready", tv_ready, 0);
      tick();
    end
    rmode = 0;
    drain();

    // Mode instructions
    put({OP_DO_DEC, 28'h0}, 1);  chk("mode_dec", {decrypt, hash}, 2'b10);
    put({OP_DO_HASH, 28'h0}, 1); chk("mode_hash", {decrypt, hash}, 2'b01);
    put({OP_DO_ENC, 28'h0}, 1);  chk("mode_enc", {decrypt, hash}, 2'b00);
    chk("no_err_yet", err, 0);

    // Zero-length load consumes the INS and emits nothing
    wq.delete();
    seg(OP_LD_PT, 4'h1, 0);
    tick();
    chk("len0_idle", {tv_ready, bdi_valid, key_valid}, 3'b100);

    // Randomized segments with random core backpressure
    rmode = 1;
    for (int s = 0; s < 24; s++) begin
      logic [3:0] op;
      int len;
      op = ops[$urandom_range(0, 5)];
      len = $urandom_range(0, 40);
      rnd_words((len + 3) / 4);
      seg(op, 4'($urandom), len);
    end
    drain();
    rmode = 0;

    // Result FIFO fill to full with consumer stopped, then pulsed drain
    res_mode = 0;
    bdo_done = 0;
    fork
      for (int i = 0; i < 5; i++) send_bdo({32'h0, 32'(i) + 32'hA0}, 4'(i + 1), 1'(i == 4));
    join_none
    repeat (10) tick();
    chk("fifo_full_bdo_ready", bdo_ready, 0);
    chk("fifo_full_res_valid", res_valid, 1);
    chk("fifo_full_accepted", bdo_done, 4);
    res_mode = 2;
    n = 0;
    while ((bdo_done < 5 || res_q.size() != 0) && n < 500) begin tick(); n++; end
    chk("fifo_drained", res_q.size(), 0);
    chk("fifo_all_sent", bdo_done, 5);

    // Random result traffic with random consumer
    res_mode = 1;
    bdo_done = 0;
    for (int i = 0; i < 12; i++) send_bdo({$urandom, $urandom}, 4'($urandom), 1'($urandom));
    n = 0;
    while (res_q.size() != 0 && n < 500) begin tick(); n++; end
    chk("rand_res_drained", res_q.size(), 0);
    repeat (3) tick();
    chk("res_empty", res_valid, 0);
`ifdef ASCON_TV_STATS_EN
    chk("stat_bdi", stat_bdi_beats, 32'(n_in));
    chk("stat_bdo", stat_bdo_beats, 32'(n_out));
`else
    chk("stat_off", {stat_bdi_beats, stat_bdo_beats}, 0);
`endif
    res_mode = 0;

    // Auth pulse and latch
    auth = 1; auth_valid = 1; tick();
    auth_valid = 0; auth = 0;
    chk("auth_pulse1", {auth_out_valid, auth_out}, 2'b11);
    tick();
    chk("auth_after1", {auth_out_valid, auth_out}, 2'b01);
    auth_valid = 1; tick();
    auth_valid = 0;
    chk("auth_pulse0", {auth_out_valid, auth_out}, 2'b10);

    // INS inside LOAD: flagged, dropped, segment still completes
    do_reset("rst2");
    put({OP_DO_DEC, 28'h0}, 1);
    wq = '{32'h01234567, 32'h89abcdef};
    model_seg(OP_LD_CT, 4'h1, 8);
    put({OP_LD_CT, 4'h1, 24'd8}, 1);
    put(wq[0], 0);
    chk("err_before_ins_in_load", err, 0);
    put({OP_DO_ENC, 28'h0}, 1);
    chk("err_ins_in_load", err, 1);
    put(wq[1], 0);
    drain();
    chk("dropped_ins_mode", {decrypt, hash}, 2'b10);
    chk("err_sticky", err, 1);

    // DAT in IDLE and unknown opcode
    do_reset("rst3");
    put(32'h55aa55aa, 0);
    chk("err_dat_idle", err, 1);
    do_reset("rst4");
    put({4'hF, 28'h0}, 1);
    chk("err_unknown_op", err, 1);
    rnd_words(3);
    seg(OP_LD_TAG, 4'h1, 10);
    drain();
    chk("err_still_set", err, 1);

    // Reset in the middle of a 3-beat PT segment
    do_reset("rst5");
    put({OP_DO_DEC, 28'h0}, 1);
    send_bdo(64'h1122334455667788, D_PTCT, 1);
    tick();
    chk("res_pending", res_valid, 1);
    rnd_words(6);
    model_seg(OP_LD_PT, 4'h0, 24);
    put({OP_LD_PT, 4'h0, 24'd24}, 1);
    for (int i = 0; i < 3; i++) put(wq[i], 0);
    chk("mid_seg_left", exp_q.size(), 2);
    do_reset("rst_mid");
    rnd_words(6);
    seg(OP_LD_PT, 4'h1, 24);
    drain();
    chk("clean_after_rst", err, 0);

    chk("final_exp_q", exp_q.size(), 0);
    chk("final_res_q", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
